// File: rtl/cpu_trace_tx.sv
// cpu_trace_tx: captures retiring-instruction trace entries {pc, inst, wdata} into a FIFO and
// streams each one as a 7-byte frame over a valid/ready byte interface.
//
// Ports:
//   clk         - single clock, rising edge
//   rst         - asynchronous active-low reset
//   trace_valid - capture strobe, one entry per high cycle
//   pc_in       - PC of retiring instruction
//   inst_in     - retiring instruction word
//   wdata_in    - register writeback data
//   capture_en  - gates trace_valid; frames already queued still drain
//   clr_ovf     - synchronous clear of overflow and drop_cnt
//   tx_data     - stream byte
//   tx_valid    - tx_data valid
//   tx_ready    - sink accepts byte
//   fifo_count  - occupied FIFO entries
//   overflow    - sticky, an entry was dropped
//   drop_cnt    - dropped entries, saturating at 8'hFF
module cpu_trace_tx #(
   parameter int unsigned DEPTH     = 8,
   parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     trace_valid,
   input  logic [15:0]              pc_in,
   input  logic [15:0]              inst_in,
   input  logic [15:0]              wdata_in,
   input  logic                     capture_en,
   input  logic                     clr_ovf,
   output logic [7:0]               tx_data,
   output logic                     tx_valid,
   input  logic                     tx_ready,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic                     overflow,
   output logic [7:0]               drop_cnt
);

   localparam int unsigned AW = $clog2(DEPTH);

   typedef enum logic {StIdle, StSend} state_t;

   logic [47:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [47:0]   frame;
   logic [2:0]    idx;
   state_t        state;

   logic full;
   logic empty;
   logic accept;
   logic frame_done;
   logic pop;
   logic push_req;
   logic push;
   logic drop;

   // Byte order on the wire: sync, then pc, inst, wdata, each MSB first.
   function automatic logic [7:0] byte_sel(input logic [47:0] f, input logic [2:0] i);
      logic [7:0] b;
      case (i)
         3'd0:    b = SYNC_BYTE;
         3'd1:    b = f[47:40];
         3'd2:    b = f[39:32];
         3'd3:    b = f[31:24];
         3'd4:    b = f[23:16];
         3'd5:    b = f[15:8];
         3'd6:    b = f[7:0];
         default: b = 8'h00;
      endcase
      return b;
   endfunction

   always_comb begin
      full       = (fifo_count == (AW+1)'(DEPTH));
      empty      = (fifo_count == '0);
      accept     = tx_valid & tx_ready;
      frame_done = (state == StSend) & accept & (idx == 3'd6);
      // Pop on entry from idle, or chained straight off the last byte for back-to-back frames.
      pop        = ~empty & ((state == StIdle) | frame_done);
      push_req   = trace_valid & capture_en;
      // A same-edge pop frees a slot, so a full FIFO can still accept.
      push       = push_req & (~full | pop);
      drop       = push_req & ~push;
   end

   // Storage is deliberately not reset.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= {pc_in, inst_in, wdata_in};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= StIdle;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         frame      <= '0;
         idx        <= '0;
         tx_valid   <= 1'b0;
         tx_data    <= 8'h00;
         overflow   <= 1'b0;
         drop_cnt   <= 8'h00;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;

         unique case ({push, pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: fifo_count <= fifo_count;
         endcase

         if (pop) begin
            frame    <= mem[rd_ptr];
            idx      <= 3'd0;
            tx_data  <= SYNC_BYTE;
            tx_valid <= 1'b1;
            state    <= StSend;
         end else if (state == StSend && accept) begin
            if (frame_done) begin
               state    <= StIdle;
               tx_valid <= 1'b0;
               tx_data  <= 8'h00;
            end else begin
               idx     <= idx + 3'd1;
               tx_data <= byte_sel(frame, idx + 3'd1);
            end
         end

         // A drop on the clearing edge wins, leaving a count of one.
         if (clr_ovf) begin
            overflow <= drop;
            drop_cnt <= drop ? 8'h01 : 8'h00;
         end else if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'h01;
         end
      end
   end

endmodule

// File: tb/tb_cpu_trace_tx.sv
module tb_cpu_trace_tx;

   localparam int unsigned DEPTH     = 8;
   localparam logic [7:0]  SYNC_BYTE = 8'hA5;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        trace_valid = 1'b0;
   logic [15:0] pc_in = '0;
   logic [15:0] inst_in = '0;
   logic [15:0] wdata_in = '0;
   logic        capture_en = 1'b1;
   logic        clr_ovf = 1'b0;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready = 1'b0;
   logic [3:0]  fifo_count;
   logic        overflow;
   logic [7:0]  drop_cnt;

   int checks = 0;
   int errors = 0;

   // Reference model: queue of pending entries plus the bytes of the frame on the wire.
   logic [47:0] mq[$];
   logic [7:0]  mout[$];
   bit          m_ovf;
   int          m_drop;

   cpu_trace_tx #(.DEPTH(DEPTH), .SYNC_BYTE(SYNC_BYTE)) dut (
      .clk        (clk),
      .rst        (rst),
      .trace_valid(trace_valid),
      .pc_in      (pc_in),
      .inst_in    (inst_in),
      .wdata_in   (wdata_in),
      .capture_en (capture_en),
      .clr_ovf    (clr_ovf),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .fifo_count (fifo_count),
      .overflow   (overflow),
      .drop_cnt   (drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      mout.delete();
      m_ovf  = 1'b0;
      m_drop = 0;
   endtask

   task automatic check_outputs();
      chk("tx_valid", 16'(tx_valid), 16'(mout.size() > 0));
      chk("tx_data", 16'(tx_data), (mout.size() > 0) ? 16'(mout[0]) : 16'h0000);
      chk("fifo_count", 16'(fifo_count), 16'(mq.size()));
      chk("overflow", 16'(overflow), 16'(m_ovf));
      chk("drop_cnt", 16'(drop_cnt), 16'(m_drop));
   endtask

   // Advance one clock: predict from current inputs, then compare just after the edge.
   task automatic cycle();
      bit          preq, acc, last, pop, push, drop;
      logic [47:0] e;
      if (rst) begin
         preq = trace_valid && capture_en;
         acc  = (mout.size() > 0) && tx_ready;
         last = acc && (mout.size() == 1);
         pop  = (mq.size() > 0) && ((mout.size() == 0) || last);
         push = preq && ((mq.size() < DEPTH) || pop);
         drop = preq && !push;
         if (acc) void'(mout.pop_front());
         if (pop) begin
            e = mq.pop_front();
            mout.push_back(SYNC_BYTE);
            mout.push_back(e[47:40]);
            mout.push_back(e[39:32]);
            mout.push_back(e[31:24]);
            mout.push_back(e[23:16]);
            mout.push_back(e[15:8]);
            mout.push_back(e[7:0]);
         end
         if (push) mq.push_back({pc_in, inst_in, wdata_in});
         if (clr_ovf) begin
            m_ovf  = drop;
            m_drop = drop ? 1 : 0;
         end else if (drop) begin
            m_ovf = 1'b1;
            if (m_drop < 255) m_drop++;
         end
      end
      @(posedge clk);
      #1;
      check_outputs();
   endtask

   task automatic set_entry(input logic [15:0] p, input logic [15:0] i, input logic [15:0] w);
      trace_valid = 1'b1;
      pc_in       = p;
      inst_in     = i;
      wdata_in    = w;
   endtask

   initial begin
      int n;
      model_reset();

      // Reset state
      #2;
      check_outputs();
      @(posedge clk); #3;
      rst = 1'b1;
      cycle();

      // Single entry, sink always ready; SYNC must appear one edge after capture
      tx_ready = 1'b1;
      set_entry(16'h0004, 16'h1234, 16'hBEEF);
      cycle();
      trace_valid = 1'b0;
      cycle();
      chk("latency_sync", 16'(tx_data), 16'h00A5);
      chk("byte0_valid", 16'(tx_valid), 16'h0001);
      for (int k = 0; k < 8; k++) cycle();
      chk("single_done", 16'(tx_valid), 16'h0000);

      // Backpressure: ready toggles every cycle
      set_entry(16'h0004, 16'h1234, 16'hBEEF);
      cycle();
      trace_valid = 1'b0;
      for (int k = 0; k < 18; k++) begin
         tx_ready = k[0];
         cycle();
      end

      // Overflow: ten pulses with the sink stalled
      tx_ready = 1'b0;
      for (int k = 0; k < 10; k++) begin
         set_entry(16'(k), 16'(16'h1000 + k), 16'(16'h2000 + k));
         cycle();
      end
      trace_valid = 1'b0;
      chk("ovf_count", 16'(fifo_count), 16'h0008);
      chk("ovf_drop", 16'(drop_cnt), 16'h0001);
      chk("ovf_flag", 16'(overflow), 16'h0001);
      clr_ovf = 1'b1;
      cycle();
      clr_ovf = 1'b0;
      chk("clr_drop", 16'(drop_cnt), 16'h0000);
      chk("clr_flag", 16'(overflow), 16'h0000);

      // Clear coinciding with a drop
      set_entry(16'hCAFE, 16'h0001, 16'h0002);
      clr_ovf = 1'b1;
      cycle();
      clr_ovf = 1'b0;
      trace_valid = 1'b0;
      chk("clr_drop_same_edge", 16'(drop_cnt), 16'h0001);

      // Saturation of drop_cnt
      set_entry(16'h1111, 16'h2222, 16'h3333);
      for (int k = 0; k < 270; k++) cycle();
      trace_valid = 1'b0;
      chk("drop_sat", 16'(drop_cnt), 16'h00FF);

      // Drain everything
      tx_ready = 1'b1;
      for (int k = 0; k < 80; k++) cycle();
      clr_ovf = 1'b1;
      cycle();
      clr_ovf = 1'b0;

      // Back-to-back frames: tx_valid must stay high for 21 cycles
      tx_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         set_entry(16'(16'hA000 + k), 16'(16'hB000 + k), 16'(16'hC000 + k));
         cycle();
      end
      trace_valid = 1'b0;
      tx_ready = 1'b1;
      for (int k = 0; k < 21; k++) begin
         chk("b2b_valid", 16'(tx_valid), 16'h0001);
         cycle();
      end
      chk("b2b_end", 16'(tx_valid), 16'h0000);

      // Mid-frame reset after byte 3 accepted
      for (int k = 0; k < 3; k++) begin
         set_entry(16'(16'h5000 + k), 16'(16'h6000 + k), 16'(16'h7000 + k));
         cycle();
      end
      trace_valid = 1'b0;
      n = 0;
      while (!(mout.size() == 3 && mq.size() > 0) && n < 20) begin
         cycle();
         n++;
      end
      chk("midreset_reached", 16'(n < 20), 16'h0001);
      rst = 1'b0;
      #1;
      chk("rst_tx_valid", 16'(tx_valid), 16'h0000);
      chk("rst_fifo_count", 16'(fifo_count), 16'h0000);
      chk("rst_tx_data", 16'(tx_data), 16'h0000);
      model_reset();
      #1;
      rst = 1'b1;
      for (int k = 0; k < 10; k++) cycle();

      // Capture disabled
      capture_en = 1'b0;
      set_entry(16'h9999, 16'h8888, 16'h7777);
      for (int k = 0; k < 5; k++) cycle();
      chk("capen_count", 16'(fifo_count), 16'h0000);
      trace_valid = 1'b0;
      capture_en = 1'b1;
      cycle();

      // Randomized traffic against the model
      for (int k = 0; k < 400; k++) begin
         trace_valid = ($urandom_range(0, 9) < 4);
         capture_en  = ($urandom_range(0, 9) != 0);
         tx_ready    = ($urandom_range(0, 9) < 7);
         clr_ovf     = ($urandom_range(0, 31) == 0);
         pc_in       = 16'($urandom);
         inst_in     = 16'($urandom);
         wdata_in    = 16'($urandom);
         cycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
